// File: rtl/alu_console_ctrl.sv
// Operator console for the ALU lab board: debounced buttons drive operand/func/op
// entry, an exec/capture step, a 32-char hex LCD image and rate-limited refresh pulses.
module alu_console_ctrl #(
    parameter int unsigned DB_CYCLES   = 20,
    parameter int unsigned REFRESH_GAP = 8,
    parameter int unsigned EXEC_CYCLES = 2
) (
    input  logic         CCLK,
    input  logic         rst,
    input  logic         btn_load,
    input  logic         btn_next,
    input  logic [3:0]   sw,
    output logic [31:0]  alu_r,
    output logic [31:0]  alu_s,
    output logic [3:0]   func,
    output logic [1:0]   alu_op,
    input  logic [31:0]  alu_res,
    input  logic         alu_zf,
    output logic [31:0]  res_q,
    output logic         led_zf,
    output logic [255:0] strdata,
    output logic         lcd_rst,
    output logic [2:0]   state
);

    localparam int unsigned DBW = $clog2(DB_CYCLES + 1);
    localparam int unsigned GW  = $clog2(REFRESH_GAP + 1) + 1;
    localparam int unsigned EW  = $clog2(EXEC_CYCLES + 1);

    typedef enum logic [2:0] {
        S_R    = 3'd0,
        S_S    = 3'd1,
        S_FN   = 3'd2,
        S_OP   = 3'd3,
        S_EXEC = 3'd4,
        S_SHOW = 3'd5
    } state_e;

    function automatic logic [7:0] hex_char(input logic [3:0] v);
        return (v < 4'd10) ? (8'h30 + {4'd0, v}) : (8'h37 + {4'd0, v});
    endfunction

    function automatic logic [255:0] fmt(input logic [31:0] r, input logic [31:0] s,
                                         input logic [3:0] f, input logic [1:0] op,
                                         input logic [31:0] res, input logic zf,
                                         input logic [2:0] st);
        logic [255:0] t;
        t = {32{8'h20}};
        for (int i = 0; i < 4; i++) begin
            t[255-8*i -: 8]      = hex_char(r[15-4*i -: 4]);
            t[255-8*(i+5) -: 8]  = hex_char(s[15-4*i -: 4]);
            t[255-8*(i+16) -: 8] = hex_char(res[15-4*i -: 4]);
        end
        t[255-8*10 -: 8] = hex_char(f);
        t[255-8*12 -: 8] = 8'h30 | {7'd0, op[1]};
        t[255-8*13 -: 8] = 8'h30 | {7'd0, op[0]};
        t[255-8*21 -: 8] = zf ? 8'h5A : 8'h2D;
        t[255-8*23 -: 8] = 8'h30 | {5'd0, st};
        return t;
    endfunction

    // Button conditioning: index 0 = load, 1 = next
    logic [1:0]     sync1_q, sync2_q, lvl_q, press_q;
    logic [DBW-1:0] cnt_q [2];

    always_ff @(posedge CCLK or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            lvl_q   <= '0;
            press_q <= '0;
            for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= {btn_next, btn_load};
            sync2_q <= sync1_q;
            for (int i = 0; i < 2; i++) begin
                press_q[i] <= 1'b0;
                if (sync2_q[i] == lvl_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == DBW'(DB_CYCLES - 1)) begin
                    lvl_q[i]   <= sync2_q[i];
                    cnt_q[i]   <= '0;
                    press_q[i] <= sync2_q[i];
                end else begin
                    cnt_q[i] <= cnt_q[i] + DBW'(1);
                end
            end
        end
    end

    logic load_p, next_p;
    assign load_p = press_q[0];
    assign next_p = press_q[1];

    state_e        state_q;
    logic [31:0]   r_q, s_q, cap_q;
    logic [3:0]    func_q;
    logic [1:0]    op_q;
    logic          zf_q;
    logic [EW-1:0] exec_q;

    // Entry sequencer; next takes priority over load in the same cycle
    always_ff @(posedge CCLK or posedge rst) begin
        if (rst) begin
            state_q <= S_R;
            r_q     <= '0;
            s_q     <= '0;
            func_q  <= '0;
            op_q    <= '0;
            cap_q   <= '0;
            zf_q    <= 1'b0;
            exec_q  <= '0;
        end else begin
            case (state_q)
                S_R: begin
                    if (next_p)      state_q <= S_S;
                    else if (load_p) r_q <= {r_q[27:0], sw};
                end
                S_S: begin
                    if (next_p)      state_q <= S_FN;
                    else if (load_p) s_q <= {s_q[27:0], sw};
                end
                S_FN: begin
                    if (next_p)      state_q <= S_OP;
                    else if (load_p) func_q <= sw;
                end
                S_OP: begin
                    if (next_p) begin
                        state_q <= S_EXEC;
                        exec_q  <= '0;
                    end else if (load_p) begin
                        op_q <= sw[1:0];
                    end
                end
                S_EXEC: begin
                    if (exec_q == EW'(EXEC_CYCLES - 1)) begin
                        cap_q   <= alu_res;
                        zf_q    <= alu_zf;
                        state_q <= S_SHOW;
                    end else begin
                        exec_q <= exec_q + EW'(1);
                    end
                end
                S_SHOW: begin
                    if (next_p) state_q <= S_R;
                end
                default: state_q <= S_R;
            endcase
        end
    end

    assign alu_r   = r_q;
    assign alu_s   = s_q;
    assign func    = func_q;
    assign alu_op  = op_q;
    assign res_q   = cap_q;
    assign led_zf  = zf_q;
    assign state   = state_q;
    assign strdata = fmt(r_q, s_q, func_q, op_q, cap_q, zf_q, state_q);

    // Refresh pacing: any text change arms a pulse, released once the gap has elapsed
    logic [255:0] prev_q;
    logic         pend_q, lcd_q, fire_c;
    logic [GW-1:0] gap_q;

    assign fire_c = pend_q && ((32'(gap_q) + 32'd1) >= 32'(REFRESH_GAP));

    always_ff @(posedge CCLK or posedge rst) begin
        if (rst) begin
            prev_q <= fmt(32'd0, 32'd0, 4'd0, 2'd0, 32'd0, 1'b0, 3'd0);
            pend_q <= 1'b1;
            gap_q  <= GW'(REFRESH_GAP);
            lcd_q  <= 1'b0;
        end else begin
            prev_q <= strdata;
            lcd_q  <= fire_c;
            pend_q <= (pend_q & ~fire_c) | (strdata != prev_q);
            if (fire_c)                          gap_q <= '0;
            else if (gap_q < GW'(REFRESH_GAP))   gap_q <= gap_q + GW'(1);
        end
    end

    assign lcd_rst = lcd_q;

endmodule
